// File: rtl/rom_ctrl_pkg.sv
// Shared ROM controller types: multi-bit booleans, digest comparator FSM encodings and helpers.
package rom_ctrl_pkg;

    typedef logic [3:0] mubi4_t;
    localparam mubi4_t MuBi4True  = 4'h6;
    localparam mubi4_t MuBi4False = 4'h9;

    localparam int LanesDefault = 2;

    // Sparse encodings, pairwise Hamming distance 4.
    typedef enum logic [5:0] {
        CmpWaiting  = 6'b000111,
        CmpChecking = 6'b011100,
        CmpDone     = 6'b110010
    } cmp_state_e;

    function automatic mubi4_t mubi4_bool_to_mubi(input logic b);
        return b ? MuBi4True : MuBi4False;
    endfunction

    function automatic int vbits(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/rom_ctrl_digest_cmp_lane.sv
// Combinational per-beat slice of the computed and expected digests, plus their equality flag.
module rom_ctrl_digest_cmp_lane
    import rom_ctrl_pkg::*;
#(
    parameter int NumWords = 8,
    parameter int Lanes    = LanesDefault,
    parameter int AW       = 2
) (
    input  logic [AW-1:0]         beat_i,
    input  logic [NumWords*32-1:0] digest_i,
    input  logic [NumWords*32-1:0] exp_digest_i,
    output logic [Lanes*32-1:0]    data_o,
    output logic                   eq_o
);

    localparam int BeatW    = Lanes * 32;
    localparam int NumBeats = NumWords / Lanes;

    logic [BeatW-1:0] exp_beat;

    // Out-of-range beat indices fall back to beat 0; the counter never produces them.
    always_comb begin
        data_o   = digest_i[BeatW-1:0];
        exp_beat = exp_digest_i[BeatW-1:0];
        for (int b = 1; b < NumBeats; b++) begin
            if (beat_i == AW'(b)) begin
                data_o   = digest_i[b*BeatW +: BeatW];
                exp_beat = exp_digest_i[b*BeatW +: BeatW];
            end
        end
        eq_o = (data_o == exp_beat);
    end

endmodule

// File: rtl/rom_ctrl_digest_cmp.sv
// ROM-check digest comparator: streams computed digest beats to the key manager and compares them
// against the expected digest. Define ROM_CTRL_CMP_MISMATCH_LOG_EN to log the first mismatching beat.
module rom_ctrl_digest_cmp
    import rom_ctrl_pkg::*;
#(
    parameter int NumWords = 8,
    parameter int Lanes    = LanesDefault,
    localparam int NumBeats = NumWords / Lanes,
    localparam int AW       = vbits(NumBeats)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   clear_i,
    input  logic [NumWords*32-1:0] digest_i,
    input  logic [NumWords*32-1:0] exp_digest_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [Lanes*32-1:0]    out_data_o,
    output logic                   done_o,
    output mubi4_t                 good_o,
    output logic [AW-1:0]          mismatch_idx_o,
    output logic                   alert_o
);

    localparam logic [AW-1:0] LastBeat = AW'(NumBeats - 1);

    // Handshake: a beat transfers on a clock edge where out_valid_o && out_ready_i; while valid is
    // high and ready is low the beat index, out_data_o and the compare accumulator all hold.

    cmp_state_e state_q, state_d;
    logic       fsm_alert;
    logic [AW-1:0] cnt_q, cnt_inv_q;
    logic       cnt_err;
    logic       beat_incr, beat_clr, beat_done, beat_eq;
    logic       matches_q;
    mubi4_t     good_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= CmpWaiting;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        fsm_alert = 1'b0;
        case (state_q)
            CmpWaiting:  if (start_i) state_d = CmpChecking;
            CmpChecking: if (cnt_q == LastBeat && out_ready_i) state_d = CmpDone;
            CmpDone:     if (clear_i) state_d = CmpWaiting;
            default:     fsm_alert = 1'b1;
        endcase
    end

    assign out_valid_o = (state_q == CmpChecking);
    assign done_o      = (state_q == CmpDone);
    assign beat_done   = out_valid_o && out_ready_i;
    assign beat_incr   = beat_done && (cnt_q != LastBeat);
    assign beat_clr    = done_o && clear_i;

    // Beat counter with a complemented shadow copy; any disagreement is an integrity error.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            cnt_inv_q <= '1;
        end else if (beat_clr) begin
            cnt_q     <= '0;
            cnt_inv_q <= '1;
        end else if (beat_incr) begin
            cnt_q     <= cnt_q + 1'b1;
            cnt_inv_q <= cnt_inv_q - 1'b1;
        end
    end

    assign cnt_err = (cnt_q != ~cnt_inv_q);

    rom_ctrl_digest_cmp_lane #(
        .NumWords (NumWords),
        .Lanes    (Lanes),
        .AW       (AW)
    ) u_lane (
        .beat_i       (cnt_q),
        .digest_i     (digest_i),
        .exp_digest_i (exp_digest_i),
        .data_o       (out_data_o),
        .eq_o         (beat_eq)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            matches_q <= 1'b1;
        end else if (beat_clr) begin
            matches_q <= 1'b1;
        end else if (beat_done) begin
            matches_q <= matches_q && beat_eq;
        end
    end

    // Registered so the verdict leaves as a clean multi-bit value, one cycle behind done_o.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            good_q <= MuBi4False;
        end else begin
            good_q <= mubi4_bool_to_mubi(matches_q && done_o);
        end
    end

    assign good_o = good_q;

`ifdef ROM_CTRL_CMP_MISMATCH_LOG_EN
    logic [AW-1:0] mismatch_idx_q;
    logic          mismatch_seen_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mismatch_idx_q  <= '0;
            mismatch_seen_q <= 1'b0;
        end else if (beat_clr) begin
            mismatch_idx_q  <= '0;
            mismatch_seen_q <= 1'b0;
        end else if (beat_done && !beat_eq && !mismatch_seen_q) begin
            mismatch_idx_q  <= cnt_q;
            mismatch_seen_q <= 1'b1;
        end
    end

    assign mismatch_idx_o = mismatch_idx_q;
`else
    assign mismatch_idx_o = '0;
`endif

    assign alert_o = fsm_alert
                   || (start_i && state_q != CmpWaiting)
                   || (clear_i && state_q != CmpDone)
                   || (state_q == CmpWaiting && cnt_q != '0)
                   || (state_q == CmpDone && cnt_q != LastBeat)
                   || cnt_err;

endmodule

// File: doc/rom_ctrl_digest_cmp.md
Name: rom_ctrl_digest_cmp

Overview:
- Next-generation ROM-check digest comparator.
- Compares a computed digest against the expected digest over NumWords 32-bit words, Lanes words per beat.
- Streams each computed digest beat to a downstream consumer (key manager) over a valid/ready handshake.
- Restartable via clear_i; optionally logs the index of the first mismatching beat.
- Sits between the ROM checker FSM / CSR digest registers and the key manager, with a hardened alert output.

Parameters:
- NumWords, 8, digest length in 32-bit words; must be >0 and a multiple of Lanes (ASSERT_INIT).
- Lanes, 2, words compared and streamed per beat; must be ≥1.
- NumBeats (localparam), NumWords/Lanes.
- AW (localparam), vbits(NumBeats); beat counter width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  start a check; legal only in Waiting
- clear_i  in  1  return Done→Waiting for a re-check; legal only in Done
- digest_i  in  NumWords*32  computed digest, word 0 at LSB
- exp_digest_i  in  NumWords*32  expected digest, word 0 at LSB
- out_valid_o  out  1  digest beat valid toward consumer
- out_ready_i  in  1  consumer accepts beat
- out_data_o  out  Lanes*32  current digest beat, lowest word at LSB
- done_o  out  1  check complete
- good_o  out  mubi4_t  all beats matched
- mismatch_idx_o  out  AW  first mismatching beat index
- alert_o  out  1  fatal consistency/integrity alert

Behaviour:
- Reset values (rst_i high): state=Waiting, beat=0, matches=1, mismatch_seen=0. Outputs: out_valid_o=0, out_data_o=beat 0 data (combinational, not flopped), done_o=0, good_o=MuBi4False, mismatch_idx_o=0, alert_o=0.
- FSM: sparse, 6-bit, min Hamming distance 4, via PRIM_FLOP_SPARSE_FSM.
  - Encodings: Waiting=6'b000111, Checking=6'b011100, Done=6'b110010.
  - Waiting→Checking: start_i.
  - Checking→Done: beat==NumBeats-1 && out_ready_i.
  - Done→Waiting: clear_i.
  - Any other encoding: fsm alert; state holds.
- Beat counter: prim_count, Width=AW, step 1, decrement disabled.
  - incr_en = Checking && out_ready_i && beat!=NumBeats-1.
  - clr_i = Done && clear_i.
  - Never wraps.
- Handshake:
  - out_valid_o = (state==Checking).
  - out_data_o = digest_i[beat*Lanes*32 +: Lanes*32].
  - A beat completes only when out_valid_o && out_ready_i.
  - With out_ready_i low, the beat holds, no compare is accumulated, and valid stays high.
- Compare: on each completed beat, matches_q <= matches_q && (digest beat == exp_digest beat).
  - Compare is full-width; no early exit, so latency is independent of data.
  - clear_i reloads matches_q=1.
- good_o: prim_mubi4_sender of mubi4_bool_to_mubi(matches_q && done).
  - Stays MuBi4False until Done.
  - Flopped, so good_o lags done_o by one cycle.
- Minimum latency: start_i to done_o = NumBeats+1 cycles with out_ready_i held high.
- Alerts (OR-ed into alert_o, combinational):
  - fsm alert.
  - start_i outside Waiting.
  - clear_i outside Done.
  - beat!=0 in Waiting.
  - beat!=NumBeats-1 in Done.
  - prim_count err_o.
- Simultaneous start_i and clear_i in Waiting: start wins; clear_alert fires.
- Reset mid-check: returns to Waiting immediately; no partial result is retained.

Optional Feature:
- Macro: ROM_CTRL_CMP_MISMATCH_LOG_EN.
- Defined:
  - On the first completed beat that mismatches, capture the beat index into mismatch_idx_o and set mismatch_seen.
  - Later mismatches do not overwrite it.
  - clear_i and reset zero it.
- Undefined: mismatch_idx_o tied to 0; no capture flops.

Decomposition:
- rom_ctrl_pkg (shared package) gains:
  - the cmp_state_e typedef and its encodings;
  - LanesDefault=2.
- Optional sub-module rom_ctrl_digest_cmp_lane: combinational per-beat slice and compare (beat index → data, eq flag). Reused by the DV scoreboard model.

Test Plan:
- Match, NumWords=8, Lanes=2, out_ready_i=1, digest=exp: pulse start → 4 beats streamed, done_o high at cycle 5, good_o=MuBi4True at cycle 6, alert_o=0.
- Mismatch only in word 5 (beat 2): done_o=1, good_o=MuBi4False; with MISMATCH_LOG_EN, mismatch_idx_o=2.
- Backpressure: drop out_ready_i for 3 cycles on beat 1 → out_data_o is stable at beat 1 during the stall, done at cycle 8, result unchanged.
- Re-check: after Done, pulse clear_i, change exp so it now matches, start again → good_o returns to MuBi4True; mismatch_idx_o=0 after clear.
- Protocol alerts: start_i during Checking, or clear_i in Waiting → alert_o=1 that same cycle.
- Fault injection: force a state encoding of 6'b111111, or force beat=1 in Waiting → alert_o=1. Separately, assert rst_i mid-check → state Waiting and all outputs at reset values.
